pll_lock_sequencer: RTL
=======================

Name: pll_lock_sequencer

Overview:
- Controller that sequences the DDR3 core PLL (50 MHz in, 400 MHz out) from power-up to a safe running state.
- Drives the PLL reset and the clkout0 output gate, and qualifies the asynchronous lock signal.
- Releases a downstream reset once the gated output clock is valid.
- Recovers from lock loss, and from lock timeouts with bounded retries.
- Runs on the free-running 50 MHz reference clock that also feeds the PLL input.

Parameters:
- RST_CYCLES, 64: cycles pll_rst is held high per attempt; legal range 1..2^16-1.
- LOCK_TIMEOUT, 50000: cycles allowed in WAIT_LOCK before retry; 1..2^20-1.
- LOCK_STABLE, 1024: consecutive synchronized-lock-high cycles required to qualify lock; 1..2^16-1.
- GATE_DLY, 16: cycles between clkout0_gate assertion and core_rst release; 1..2^16-1.
- MAX_RETRY, 4: timeouts tolerated before the sticky FAIL state; 1..15.

Ports:
- clk  in  1  50 MHz reference clock, free-running, same net as PLL clkin1.
- rst  in  1  synchronous, active-high reset.
- restart  in  1  single-cycle pulse; re-runs the sequence from any state, including FAIL.
- pll_lock  in  1  PLL lock, asynchronous to clk.
- pll_rst  out  1  PLL reset, active high.
- clkout0_gate  out  1  PLL clkout0 gate enable, 1 = clock runs.
- core_rst  out  1  downstream reset, active high.
- pll_ready  out  1  high only in RUN.
- fail  out  1  high only in FAIL.
- retry_cnt  out  4  timeouts since the last successful lock.
- loss_cnt  out  8  lock-loss events since reset, saturating.
- state  out  3  current state encoding, for debug.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state = RESET, pll_rst = 1, clkout0_gate = 0, core_rst = 1, pll_ready = 0, fail = 0, retry_cnt = 0, loss_cnt = 0. The cycle counter is cleared.
- Lock synchronizer: pll_lock passes through a 2-flop synchronizer giving lock_s, a 2-cycle latency. Only lock_s is used internally.
- One shared cycle counter of 20 bits, cleared on every state transition.

States and encodings:
- RESET (0): pll_rst = 1, gate = 0, core_rst = 1. Go to WAIT_LOCK when the counter reaches RST_CYCLES-1.
- WAIT_LOCK (1): pll_rst = 0.
  - If lock_s = 1, go to STABLE.
  - Else, when the counter reaches LOCK_TIMEOUT-1, increment retry_cnt. If the new retry_cnt equals MAX_RETRY, go to FAIL; otherwise go to RESET.
- STABLE (2):
  - lock_s = 0 returns to WAIT_LOCK. The counter restarts and retry_cnt is unchanged.
  - When the counter reaches LOCK_STABLE-1 with lock_s still 1, go to GATE, and clear retry_cnt.
- GATE (3): clkout0_gate = 1, core_rst = 1. Go to RUN when the counter reaches GATE_DLY-1.
- RUN (4): gate = 1, core_rst = 0, pll_ready = 1.
- FAIL (5): pll_rst = 1, gate = 0, core_rst = 1, fail = 1. Only rst or restart exits this state.
- Encodings 6 and 7 are illegal. On the next cycle they go to RESET.

Lock loss and restart:
- Lock loss: lock_s = 0 in GATE or RUN moves to RESET on the next cycle and increments loss_cnt, saturating at 255.
- On that same transition edge, clkout0_gate drops to 0 and core_rst rises to 1. They must never lag the state change.
- restart = 1 in any state moves to RESET and clears retry_cnt. loss_cnt is unchanged.
- restart has priority over every other transition in the same cycle.
- rst has priority over restart.

Output rules:
- All outputs are registered and decoded from the next state, so outputs change on the same edge as state.
- core_rst = 0 implies clkout0_gate = 1 and at least LOCK_STABLE + GATE_DLY qualified cycles since the last pll_rst.
- pll_rst and clkout0_gate are never high together.

Test Plan:
- Normal bring-up: release rst, pll_lock rises 100 cycles after pll_rst falls and stays high. Required: pll_rst high for exactly 64 cycles; clkout0_gate rises 64+100+2+1024 cycles after rst release (±1); core_rst falls 16 cycles later; pll_ready = 1; retry_cnt = 0.
- Lock glitch in STABLE: pll_lock drops for 3 cycles at stable count 500. Required: return to WAIT_LOCK; full 1024-cycle requalification; gate asserted 1024 cycles after lock_s returns; loss_cnt = 0.
- Timeout and retries: pll_lock held low. Required: 4 cycles of 64 reset + 50000 wait; retry_cnt steps 1→2→3 while retrying; the 4th timeout enters FAIL (state = 5, fail = 1, pll_rst = 1); state stays there for 10000 cycles.
- Recovery from FAIL: pulse restart while pll_lock is held high. Required: RESET next cycle; retry_cnt = 0; normal bring-up timing as in the first scenario; pll_ready = 1.
- Lock loss in RUN: drop pll_lock for 1 cycle. Required: 2 cycles of sync latency, then the gate drops and core_rst rises on the same edge; loss_cnt = 1; the full sequence reruns.
- Simultaneous events: assert restart in the cycle WAIT_LOCK times out at retry_cnt = 3. Required: RESET, retry_cnt = 0, no FAIL. Then force 255 lock losses plus 1 more: loss_cnt holds at 255.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL power-up, lock qualification, clock gating and recovery sequencer
module pll_lock_sequencer #(
  parameter int RST_CYCLES   = 64,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int LOCK_STABLE  = 1024,
  parameter int GATE_DLY     = 16,
  parameter int MAX_RETRY    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic       clkout0_gate,
  output logic       core_rst,
  output logic       pll_ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_GATE      = 3'd3,
    S_RUN       = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  localparam logic [19:0] RST_LAST   = 20'(RST_CYCLES - 1);
  localparam logic [19:0] TO_LAST    = 20'(LOCK_TIMEOUT - 1);
  localparam logic [19:0] STB_LAST   = 20'(LOCK_STABLE - 1);
  localparam logic [19:0] GATE_LAST  = 20'(GATE_DLY - 1);
  localparam logic [3:0]  RETRY_LIM  = 4'(MAX_RETRY);

  state_t      cur;
  state_t      nxt;
  logic [19:0] cnt;
  logic        lock_m;
  logic        lock_s;
  logic [3:0]  retry_nx;
  logic [7:0]  loss_nx;
  logic [7:0]  loss_inc;

  assign state    = cur;
  assign loss_inc = (loss_cnt == 8'hff) ? loss_cnt : loss_cnt + 8'd1;

  always_comb begin
    nxt      = cur;
    retry_nx = retry_cnt;
    loss_nx  = loss_cnt;
    case (cur)
      S_RESET:     if (cnt == RST_LAST) nxt = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (lock_s) begin
          nxt = S_STABLE;
        end else if (cnt == TO_LAST) begin
          retry_nx = retry_cnt + 4'd1;
          nxt      = (retry_nx == RETRY_LIM) ? S_FAIL : S_RESET;
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          nxt = S_WAIT_LOCK;
        end else if (cnt == STB_LAST) begin
          nxt      = S_GATE;
          retry_nx = 4'd0;
        end
      end
      S_GATE: begin
        if (!lock_s) begin
          nxt     = S_RESET;
          loss_nx = loss_inc;
        end else if (cnt == GATE_LAST) begin
          nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          nxt     = S_RESET;
          loss_nx = loss_inc;
        end
      end
      S_FAIL:  nxt = S_FAIL;
      default: nxt = S_RESET;
    endcase
    // restart wins over any lock-loss or timeout seen in the same cycle
    if (restart) begin
      nxt      = S_RESET;
      retry_nx = 4'd0;
      loss_nx  = loss_cnt;
    end
  end

  // outputs decode nxt so gate/reset never lag the state register
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_m       <= 1'b0;
      lock_s       <= 1'b0;
      cur          <= S_RESET;
      cnt          <= 20'd0;
      retry_cnt    <= 4'd0;
      loss_cnt     <= 8'd0;
      pll_rst      <= 1'b1;
      clkout0_gate <= 1'b0;
      core_rst     <= 1'b1;
      pll_ready    <= 1'b0;
      fail         <= 1'b0;
    end else begin
      lock_m       <= pll_lock;
      lock_s       <= lock_m;
      cur          <= nxt;
      cnt          <= ((nxt != cur) || restart) ? 20'd0 : cnt + 20'd1;
      retry_cnt    <= retry_nx;
      loss_cnt     <= loss_nx;
      pll_rst      <= (nxt == S_RESET) || (nxt == S_FAIL);
      clkout0_gate <= (nxt == S_GATE) || (nxt == S_RUN);
      core_rst     <= (nxt != S_RUN);
      pll_ready    <= (nxt == S_RUN);
      fail         <= (nxt == S_FAIL);
    end
  end

endmodule
